// File: rtl/serial_subtractor_ctrl_if.sv
// Handshake and operand/result bundle between a requesting master and serial_subtractor_ctrl.
// SERIAL_SUB_ZERO_FLAG_EN adds the registered zero flag to the bundle.
interface serial_subtractor_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
  logic             zero;
`endif

`ifdef SERIAL_SUB_ZERO_FLAG_EN
  modport master (output start, a_in, b_in, input busy, done, diff, borrow_out, zero);
  modport slave  (input start, a_in, b_in, output busy, done, diff, borrow_out, zero);
`else
  modport master (output start, a_in, b_in, input busy, done, diff, borrow_out);
  modport slave  (input start, a_in, b_in, output busy, done, diff, borrow_out);
`endif
endinterface

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial WIDTH-bit unsigned subtractor sequencer around one 1-bit subtract cell, LSB first.
// Optional SERIAL_SUB_ZERO_FLAG_EN adds a zero flag built from a sticky nonzero FF.
//
// state | meaning
// IDLE  | waiting for start; operands captured on accept
// RUN   | one bit per cycle through the cell, WIDTH cycles
// DONE  | one-cycle done pulse, results valid
module serial_subtractor_ctrl #(
  parameter int WIDTH = 8
) (
  input logic                    clk,
  input logic                    rst_n,
  serial_subtractor_ctrl_if.slave bus
);
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] diff_sr_q, diff_sr_d;
  logic             borrow_q, borrow_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_out_q, borrow_out_d;
  logic             cell_diff, cell_bout;
  logic             accept, last_bit;

  assign cell_diff = a_sr_q[0] ^ b_sr_q[0] ^ borrow_q;
  assign cell_bout = (~a_sr_q[0] & b_sr_q[0]) | (~(a_sr_q[0] ^ b_sr_q[0]) & borrow_q);

  assign accept   = (state_q == IDLE) && bus.start;
  assign last_bit = (state_q == RUN) && (cnt_q == LAST_BIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (cnt_q == LAST_BIT) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d        = cnt_q;
    a_sr_d       = a_sr_q;
    b_sr_d       = b_sr_q;
    diff_sr_d    = diff_sr_q;
    borrow_d     = borrow_q;
    diff_d       = diff_q;
    borrow_out_d = borrow_out_q;
    if (accept) begin
      cnt_d    = '0;
      a_sr_d   = bus.a_in;
      b_sr_d   = bus.b_in;
      borrow_d = 1'b0;
    end else if (state_q == RUN) begin
      cnt_d     = cnt_q + CNT_W'(1);
      a_sr_d    = {1'b0, a_sr_q[WIDTH-1:1]};
      b_sr_d    = {1'b0, b_sr_q[WIDTH-1:1]};
      diff_sr_d = {cell_diff, diff_sr_q[WIDTH-1:1]};
      borrow_d  = cell_bout;
      // results only move on the edge into DONE so they stay stable through RUN
      if (last_bit) begin
        diff_d       = {cell_diff, diff_sr_q[WIDTH-1:1]};
        borrow_out_d = cell_bout;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      a_sr_q       <= '0;
      b_sr_q       <= '0;
      diff_sr_q    <= '0;
      borrow_q     <= 1'b0;
      diff_q       <= '0;
      borrow_out_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      a_sr_q       <= a_sr_d;
      b_sr_q       <= b_sr_d;
      diff_sr_q    <= diff_sr_d;
      borrow_q     <= borrow_d;
      diff_q       <= diff_d;
      borrow_out_q <= borrow_out_d;
    end
  end

`ifdef SERIAL_SUB_ZERO_FLAG_EN
  logic nonzero_q, nonzero_d;
  logic zero_q, zero_d;

  always_comb begin
    nonzero_d = nonzero_q;
    zero_d    = zero_q;
    if (accept) begin
      nonzero_d = 1'b0;
    end else if (state_q == RUN) begin
      nonzero_d = nonzero_q | cell_diff;
      if (last_bit) zero_d = ~(nonzero_q | cell_diff);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nonzero_q <= 1'b0;
      zero_q    <= 1'b0;
    end else begin
      nonzero_q <= nonzero_d;
      zero_q    <= zero_d;
    end
  end

  assign bus.zero = zero_q;
`endif

  assign bus.busy       = (state_q == RUN);
  assign bus.done       = (state_q == DONE);
  assign bus.diff       = diff_q;
  assign bus.borrow_out = borrow_out_q;
endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Directed bench for serial_subtractor_ctrl at WIDTH = 8: vector table plus abort,
// ignored-start and back-to-back sequences. Zero flag checked when SERIAL_SUB_ZERO_FLAG_EN is set.
module tb_serial_subtractor_ctrl;
  localparam int WIDTH = 8;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  logic [WIDTH-1:0] hold_diff;
  logic             hold_borrow;
  logic             hold_zero;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] d;
    logic             bo;
    logic             z;
  } vec_t;

  vec_t vecs[7];

  serial_subtractor_ctrl_if #(.WIDTH(WIDTH)) bus ();

  serial_subtractor_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_results(input string tag, input logic [WIDTH-1:0] d, input logic bo,
                               input logic z);
    check({tag, "_diff"}, 32'(bus.diff), 32'(d));
    check({tag, "_borrow"}, 32'(bus.borrow_out), 32'(bo));
`ifdef SERIAL_SUB_ZERO_FLAG_EN
    check({tag, "_zero"}, 32'(bus.zero), 32'(z));
`else
    if (z === 1'bx) check({tag, "_zero_x"}, 32'(z), 32'(0));
`endif
  endtask

  // glitch_at >= 0 re-pulses start with other operands at that RUN sample
  task automatic run_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [WIDTH-1:0] d, input logic bo, input logic z,
                        input int glitch_at);
    int n;
    int busy_cnt;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a_in  = a;
    bus.b_in  = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a_in  = ~a;
    bus.b_in  = ~b;
    n = 0;
    busy_cnt = 0;
    while (bus.done !== 1'b1 && n < 2 * WIDTH) begin
      if (n == glitch_at) begin
        bus.start = 1'b1;
        bus.a_in  = 8'h77;
        bus.b_in  = 8'h11;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.busy === 1'b1) busy_cnt++;
      if (n == 0 || n == WIDTH - 1)
        check({tag, "_hold_diff"}, 32'(bus.diff), 32'(hold_diff));
      @(negedge clk);
      n++;
    end
    bus.start = 1'b0;
    check({tag, "_done_latency"}, 32'(n), 32'(WIDTH));
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(WIDTH));
    check({tag, "_busy_in_done"}, 32'(bus.busy), 32'(0));
    check_results(tag, d, bo, z);
    @(negedge clk);
    check({tag, "_done_pulse_width"}, 32'(bus.done), 32'(0));
    hold_diff   = d;
    hold_borrow = bo;
    hold_zero   = z;
  endtask

  initial begin
    int done_cnt;
    int k_acc;
    int k_done;
    int last_done;
    logic prev_busy;
    logic [WIDTH-1:0] bb_a[3];
    logic [WIDTH-1:0] bb_b[3];
    logic [WIDTH-1:0] bb_d[3];
    logic             bb_bo[3];

    n_checks = 0;
    n_fail   = 0;
    vecs[0] = '{a: 8'h5A, b: 8'h3C, d: 8'h1E, bo: 1'b0, z: 1'b0};
    vecs[1] = '{a: 8'h10, b: 8'h20, d: 8'hF0, bo: 1'b1, z: 1'b0};
    vecs[2] = '{a: 8'h00, b: 8'h01, d: 8'hFF, bo: 1'b1, z: 1'b0};
    vecs[3] = '{a: 8'hFF, b: 8'hFF, d: 8'h00, bo: 1'b0, z: 1'b1};
    vecs[4] = '{a: 8'h80, b: 8'h01, d: 8'h7F, bo: 1'b0, z: 1'b0};
    vecs[5] = '{a: 8'h01, b: 8'h80, d: 8'h81, bo: 1'b1, z: 1'b0};
    vecs[6] = '{a: 8'hA5, b: 8'h5A, d: 8'h4B, bo: 1'b0, z: 1'b0};
    bb_a = '{8'h5A, 8'h10, 8'hFF};
    bb_b = '{8'h3C, 8'h20, 8'hFF};
    bb_d = '{8'h1E, 8'hF0, 8'h00};
    bb_bo = '{1'b0, 1'b1, 1'b0};

    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a_in  = '0;
    bus.b_in  = '0;
    hold_diff = '0;
    hold_borrow = 1'b0;
    hold_zero = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(bus.busy), 32'(0));
    check("reset_done", 32'(bus.done), 32'(0));
    check_results("reset", 8'h00, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_no_start_busy", 32'(bus.busy), 32'(0));

    for (int i = 0; i < 7; i++)
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].bo, vecs[i].z, -1);

    // start during RUN must not disturb the operation in flight
    run_op("ignore_start", 8'h5A, 8'h3C, 8'h1E, 1'b0, 1'b0, 3);
    done_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      if (bus.done === 1'b1) done_cnt++;
      if (bus.busy === 1'b1) done_cnt++;
      @(negedge clk);
    end
    check("ignore_start_extra_activity", 32'(done_cnt), 32'(0));
    check_results("ignore_start_hold", 8'h1E, 1'b0, 1'b0);

    // abort mid-RUN
    bus.start = 1'b1;
    bus.a_in  = 8'h5A;
    bus.b_in  = 8'h3C;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_pre_busy", 32'(bus.busy), 32'(1));
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(bus.busy), 32'(0));
    check("abort_done", 32'(bus.done), 32'(0));
    check_results("abort", 8'h00, 1'b0, 1'b0);
    done_cnt = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1) done_cnt++;
    end
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) done_cnt++;
    end
    check("abort_no_done", 32'(done_cnt), 32'(0));
    hold_diff = '0;
    run_op("after_abort", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, -1);

    // back-to-back with start held high
    @(negedge clk);
    bus.start = 1'b1;
    bus.a_in  = bb_a[0];
    bus.b_in  = bb_b[0];
    k_acc = 0;
    k_done = 0;
    last_done = -1;
    prev_busy = 1'b0;
    for (int c = 0; c < 60 && k_done < 3; c++) begin
      @(negedge clk);
      if (bus.busy === 1'b1 && !prev_busy) begin
        k_acc++;
        bus.a_in = (k_acc < 3) ? bb_a[k_acc] : 8'h00;
        bus.b_in = (k_acc < 3) ? bb_b[k_acc] : 8'h00;
      end
      if (bus.done === 1'b1) begin
        check($sformatf("b2b%0d_diff", k_done), 32'(bus.diff), 32'(bb_d[k_done]));
        check($sformatf("b2b%0d_borrow", k_done), 32'(bus.borrow_out), 32'(bb_bo[k_done]));
        if (k_done > 0) check($sformatf("b2b%0d_spacing", k_done), 32'(c - last_done), 32'(WIDTH + 2));
        last_done = c;
        k_done++;
        if (k_done == 3) bus.start = 1'b0;
      end
      prev_busy = bus.busy;
    end
    check("b2b_done_count", 32'(k_done), 32'(3));
    check("b2b_accept_count", 32'(k_acc), 32'(3));
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check("b2b_idle_after", 32'(bus.busy), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
